matrix_operand_fetch: RTL
=========================

MATRIX_OPERAND_FETCH -- requirements
Module: matrix_operand_fetch

Interface
REQ-001 Parameter DATA_W, 8, width of one matrix element and of the RAM word.
REQ-002 Parameter ADDR_W, 5, RAM address width (32-word single-port RAM).
REQ-003 Parameter N_ELEM, 4, elements per matrix; legal range 1..2**(ADDR_W-1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request one fetch of matrix A then matrix B; sampled only in IDLE.
REQ-007 base_a  input  ADDR_W  RAM address of A element 0; sampled with start.
REQ-008 base_b  input  ADDR_W  RAM address of B element 0; sampled with start.
REQ-009 ram_addr  output  ADDR_W  registered read address to the RAM.
REQ-010 ram_q  input  DATA_W  RAM read data; valid two edges after ram_addr changes.
REQ-011 mat_a  output  N_ELEM*DATA_W  packed matrix A; element j at bits [j*DATA_W +: DATA_W].
REQ-012 mat_b  output  N_ELEM*DATA_W  packed matrix B, same packing.
REQ-013 out_valid  output  1  mat_a/mat_b complete and stable; drives the adder's activate.
REQ-014 out_ready  input  1  consumer accepts operands when high with out_valid.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, FETCH, DRAIN, HOLD.
REQ-017 IDLE: start=1 at edge E0 SHALL latch base_a/base_b, set ram_addr=base_a, element counter k=0, go FETCH.
REQ-018 FETCH: at each edge ram_addr SHALL advance; element k (k=0..2N-1) addressed after edge Ek, A elements base_a+k, B elements base_b+(k-N).
REQ-019 Address arithmetic SHALL be modulo 2**ADDR_W (base 31 + 1 wraps to 0).
REQ-020 ram_q for element k SHALL be captured at edge E(k+2); k<N into mat_a slot k, else mat_b slot k-N.
REQ-021 After issuing element 2N-1 SHALL go DRAIN; ram_addr holds last value until IDLE.
REQ-022 Last capture at E(2N+1) SHALL coincide with entry to HOLD; out_valid high from E(2N+1), total latency 2N+1 cycles from start.
REQ-023 HOLD: mat_a, mat_b, out_valid SHALL stay stable while out_ready=0.
REQ-024 HOLD with out_ready=1 at an edge SHALL drop out_valid and return to IDLE; mat_a/mat_b retain values.
REQ-025 start outside IDLE SHALL be ignored, including the edge that completes the HOLD handshake; no queuing.
REQ-026 base_a equal to base_b or overlapping ranges SHALL be legal; RAM contents read as-is.
REQ-027 The block SHALL never write the RAM; its wren and data tie off at the parent.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, ram_addr=0, k=0, mat_a=0, mat_b=0, out_valid=0, busy=0.
REQ-029 rst during FETCH/DRAIN/HOLD SHALL abort the transfer; no out_valid pulse follows release.
REQ-030 First start after rst release SHALL behave exactly as REQ-017.

Structure
REQ-031 Package matrix_pkg SHALL hold DATA_W, ADDR_W, N_ELEM defaults and the state encoding constants.
REQ-032 One sub-module, matrix_addr_gen (base latch, counter, wrapping adder, A/B select), SHALL produce ram_addr and k; capture and FSM stay in the top.
REQ-033 Target size 120-400 lines RTL; no latches, no combinational path from ram_q to outputs.

Verification
REQ-034 RAM[i]=i+1, base_a=0, base_b=4, N=4, start 1 cycle, out_ready=1 -> out_valid at E9, mat_a=0x04030201, mat_b=0x08070605, busy low after E10.
REQ-035 Same load, out_ready=0 for 5 cycles after out_valid, start pulsed during HOLD -> outputs unchanged, no second fetch, IDLE one edge after out_ready=1.
REQ-036 base_a=30, base_b=2, RAM[i]=i -> ram_addr sequence 30,31,0,1,2,3,4,5; mat_a=0x01001F1E, mat_b=0x05040302.
REQ-037 rst asserted asynchronously mid-cycle 3 of FETCH -> outputs zero immediately, out_valid never rises; next start yields REQ-034 result.
REQ-038 Back-to-back: start re-asserted the cycle after handshake with base_a=4, base_b=0 -> mat_a=0x08070605, mat_b=0x04030201 at 9 edges after accepted start.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared defaults and FSM state type for the matrix operand fetch block.
package matrix_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_N_ELEM = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/matrix_addr_gen.sv
// Address generator: latches both base addresses, counts elements and
// produces the wrapping RAM read address for A then B.
module matrix_addr_gen #(
    parameter int ADDR_W = 5,
    parameter int N_ELEM = 4,
    parameter int K_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [K_W-1:0]    k
);

    localparam logic [K_W-1:0] N_K = K_W'(N_ELEM);

    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [K_W-1:0]    k_next;
    logic [ADDR_W-1:0] addr_next;

    // Truncation to ADDR_W bits gives the modulo-2**ADDR_W wrap.
    always_comb begin
        k_next = k + K_W'(1);
        if (k_next < N_K) begin
            addr_next = base_a_q + ADDR_W'(k_next);
        end else begin
            addr_next = base_b_q + ADDR_W'(k_next - N_K);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_a_q <= '0;
            base_b_q <= '0;
            k        <= '0;
            ram_addr <= '0;
        end else if (load) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            k        <= '0;
            ram_addr <= base_a;
        end else if (advance) begin
            k        <= k_next;
            ram_addr <= addr_next;
        end
    end

endmodule

// File: rtl/matrix_operand_fetch.sv
// Fetches matrix A then matrix B from a registered-read RAM and presents
// both as packed operands under a valid/ready handshake.
module matrix_operand_fetch
    import matrix_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_ELEM = DEF_N_ELEM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_a,
    input  logic [ADDR_W-1:0]        base_b,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [DATA_W-1:0]        ram_q,
    output logic [N_ELEM*DATA_W-1:0] mat_a,
    output logic [N_ELEM*DATA_W-1:0] mat_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int K_W = $clog2(2 * N_ELEM);
    localparam logic [K_W-1:0] LAST_K     = K_W'(2 * N_ELEM - 1);
    localparam logic [K_W-1:0] PRE_LAST_K = K_W'(2 * N_ELEM - 2);

    state_t         state;
    state_t         state_next;
    logic           load;
    logic           advance;
    logic [K_W-1:0] k;
    logic           addr_vld;
    logic           cap_vld;
    logic [K_W-1:0] cap_k;

    matrix_addr_gen #(
        .ADDR_W (ADDR_W),
        .N_ELEM (N_ELEM),
        .K_W    (K_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .advance  (advance),
        .base_a   (base_a),
        .base_b   (base_b),
        .ram_addr (ram_addr),
        .k        (k)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                advance = 1'b1;
                if (k == PRE_LAST_K) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_vld && cap_k == LAST_K) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // Two-stage tag pipeline tracks which element the RAM returns this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_vld <= 1'b0;
            cap_vld  <= 1'b0;
            cap_k    <= '0;
            mat_a    <= '0;
            mat_b    <= '0;
        end else begin
            state    <= state_next;
            addr_vld <= load | advance;
            cap_vld  <= addr_vld;
            cap_k    <= k;
            if (cap_vld) begin
                for (int unsigned j = 0; j < unsigned'(N_ELEM); j++) begin
                    if (cap_k == K_W'(j)) begin
                        mat_a[j*DATA_W +: DATA_W] <= ram_q;
                    end
                    if (cap_k == K_W'(j + unsigned'(N_ELEM))) begin
                        mat_b[j*DATA_W +: DATA_W] <= ram_q;
                    end
                end
            end
        end
    end

endmodule
